// File: rtl/nibble_ctrl_pkg.sv
// Shared opcodes, ALU select codes, FSM encoding and decoded-control bundle
// for the nibble microsequencer.
package nibble_ctrl_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_LDI   = 4'b0001;
  localparam logic [3:0] OP_ADDI  = 4'b0010;
  localparam logic [3:0] OP_SUBI  = 4'b0011;
  localparam logic [3:0] OP_NANDI = 4'b0100;
  localparam logic [3:0] OP_OUT   = 4'b0101;
  localparam logic [3:0] OP_JMP   = 4'b0110;
  localparam logic [3:0] OP_JC    = 4'b0111;
  localparam logic [3:0] OP_JZ    = 4'b1000;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [2:0] SEL_A    = 3'b000;
  localparam logic [2:0] SEL_AMB  = 3'b001;
  localparam logic [2:0] SEL_B    = 3'b010;
  localparam logic [2:0] SEL_APB  = 3'b011;
  localparam logic [2:0] SEL_NAND = 3'b100;

  localparam logic [1:0] JCOND_ALWAYS = 2'd0;
  localparam logic [1:0] JCOND_CARRY  = 2'd1;
  localparam logic [1:0] JCOND_ZERO   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  typedef struct packed {
    logic       ea;
    logic       eb;
    logic       ec;
    logic [2:0] slct;
    logic       set_flags;
    logic       is_jmp;
    logic [1:0] jmp_cond;
    logic       is_halt;
  } dec_t;

endpackage

// File: rtl/nibble_ctrl_decode.sv
// Combinational opcode decoder: maps the instruction opcode onto the datapath
// enables, ALU select and the sequencing attributes used by the FSM.
module nibble_ctrl_decode
  import nibble_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    dec.slct = SEL_A;
    dec.jmp_cond = JCOND_ALWAYS;
    case (opcode)
      OP_LDI:   begin dec.ea = 1'b1; dec.ec = 1'b1; dec.slct = SEL_B; end
      OP_ADDI:  begin dec.ea = 1'b1; dec.ec = 1'b1; dec.slct = SEL_APB;  dec.set_flags = 1'b1; end
      OP_SUBI:  begin dec.ea = 1'b1; dec.ec = 1'b1; dec.slct = SEL_AMB;  dec.set_flags = 1'b1; end
      OP_NANDI: begin dec.ea = 1'b1; dec.ec = 1'b1; dec.slct = SEL_NAND; dec.set_flags = 1'b1; end
      OP_OUT:   dec.eb = 1'b1;
      OP_JMP:   dec.is_jmp = 1'b1;
      OP_JC:    begin dec.is_jmp = 1'b1; dec.jmp_cond = JCOND_CARRY; end
      OP_JZ:    begin dec.is_jmp = 1'b1; dec.jmp_cond = JCOND_ZERO; end
      OP_HALT:  dec.is_halt = 1'b1;
      default:  dec = dec;
    endcase
  end

endmodule

// File: rtl/nibble_seq_ctrl.sv
// Fetch/decode/execute microsequencer for the 4-bit accumulator datapath.
// All datapath controls are registered and live only during the EXEC cycle.
module nibble_seq_ctrl
  import nibble_ctrl_pkg::*;
#(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               carry_in,
  input  logic               zero_in,
  output logic [PC_W-1:0]    pc,
  output logic [3:0]         oprnd,
  output logic               ea,
  output logic               eb,
  output logic               ec,
  output logic [2:0]         slct,
  output logic               busy,
  output logic               halted
);

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               c_q, c_d, z_q, z_d;
  logic [3:0]         oprnd_q, oprnd_d;
  logic               ea_q, ea_d, eb_q, eb_d, ec_q, ec_d;
  logic [2:0]         slct_q, slct_d;
  logic               busy_q, busy_d, halted_q, halted_d;
  dec_t               dec;
  logic               cond_ok;

  nibble_ctrl_decode u_decode (
    .opcode (ir_q[7:4]),
    .dec    (dec)
  );

  always_comb begin
    case (dec.jmp_cond)
      JCOND_CARRY: cond_ok = c_q;
      JCOND_ZERO:  cond_ok = z_q;
      default:     cond_ok = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    c_d     = c_q;
    z_d     = z_q;
    oprnd_d = oprnd_q;
    ea_d    = 1'b0;
    eb_d    = 1'b0;
    ec_d    = 1'b0;
    slct_d  = SEL_A;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          c_d     = 1'b0;
          z_d     = 1'b0;
        end
      end
      ST_FETCH: begin
        ir_d    = imem_data;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        ea_d    = dec.ea;
        eb_d    = dec.eb;
        ec_d    = dec.ec;
        slct_d  = dec.slct;
        oprnd_d = ir_q[3:0];
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // The ALU result is settled during EXEC, so flags are captured at its end.
        if (dec.set_flags) begin
          c_d = carry_in;
          z_d = zero_in;
        end
        if (dec.is_halt) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
          pc_d    = (dec.is_jmp && cond_ok) ? PC_W'(ir_q[3:0]) : pc_q + PC_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d   = (state_d == ST_FETCH) || (state_d == ST_DECODE) || (state_d == ST_EXEC);
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      oprnd_q  <= '0;
      ea_q     <= 1'b0;
      eb_q     <= 1'b0;
      ec_q     <= 1'b0;
      slct_q   <= SEL_A;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      c_q      <= c_d;
      z_q      <= z_d;
      oprnd_q  <= oprnd_d;
      ea_q     <= ea_d;
      eb_q     <= eb_d;
      ec_q     <= ec_d;
      slct_q   <= slct_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign pc     = pc_q;
  assign oprnd  = oprnd_q;
  assign ea     = ea_q;
  assign eb     = eb_q;
  assign ec     = ec_q;
  assign slct   = slct_q;
  assign busy   = busy_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_nibble_seq_ctrl.sv
// Bench for nibble_seq_ctrl: accumulator/ALU datapath model, single-instruction
// vector table, directed programs and random programs against an ISA-level model.
module tb_nibble_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] imem_data;
  logic       carry_in, zero_in;
  logic [3:0] pc, oprnd;
  logic       ea, eb, ec;
  logic [2:0] slct;
  logic       busy, halted;

  logic [7:0] rom [16];
  logic [3:0] acc;
  logic       acc_clr;
  logic [3:0] alu_b;
  logic [4:0] alu_w;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] m_pc, m_acc;
  logic       m_c, m_z, m_halt;

  nibble_seq_ctrl #(.PC_W(4), .INSTR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .imem_data(imem_data),
    .carry_in(carry_in), .zero_in(zero_in), .pc(pc), .oprnd(oprnd),
    .ea(ea), .eb(eb), .ec(ec), .slct(slct), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  assign imem_data = rom[pc];

  // Datapath: ALU with carry = carry-out of A + B or A + ~B + 1, accumulator on ec.
  always_comb begin
    alu_b = ea ? oprnd : 4'd0;
    case (slct)
      3'b000:  alu_w = {1'b0, acc};
      3'b001:  alu_w = {1'b0, acc} + {1'b0, ~alu_b} + 5'd1;
      3'b010:  alu_w = {1'b0, alu_b};
      3'b011:  alu_w = {1'b0, acc} + {1'b0, alu_b};
      3'b100:  alu_w = {1'b0, ~(acc & alu_b)};
      default: alu_w = 5'd0;
    endcase
  end
  assign carry_in = alu_w[4];
  assign zero_in  = (alu_w[3:0] == 4'd0);

  always @(posedge clk) begin
    if (acc_clr) acc <= 4'd0;
    else if (ec) acc <= alu_w[3:0];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] ctl_now();
    return {ea, eb, ec, slct};
  endfunction

  // Expected {ea,eb,ec,slct} for each opcode, straight from the instruction table.
  function automatic logic [5:0] exp_ctl(input logic [3:0] op);
    case (op)
      4'h1:    return 6'b101_010;
      4'h2:    return 6'b101_011;
      4'h3:    return 6'b101_001;
      4'h4:    return 6'b101_100;
      4'h5:    return 6'b010_000;
      default: return 6'b000_000;
    endcase
  endfunction

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1; acc_clr = 1'b1; start = 1'b0;
    tick();
    chk("rst_pc", 32'(pc), 0);
    chk("rst_oprnd", 32'(oprnd), 0);
    chk("rst_ctl", 32'(ctl_now()), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_halted", 32'(halted), 0);
    reset = 1'b0; acc_clr = 1'b0; m_acc = 4'd0;
    tick();
    chk("idle_busy", 32'(busy), 0);
  endtask

  // Runs the ROM program from pc 0 for up to max_instr instructions, checking every cycle.
  task automatic run_prog(input int max_instr, input int poke_at);
    logic [7:0] ins;
    logic [3:0] op, v;
    logic [4:0] s;
    m_pc = 4'd0; m_c = 1'b0; m_z = 1'b0; m_halt = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < max_instr && !m_halt; k++) begin
      for (int ph = 0; ph < 2; ph++) begin
        chk("busy_fd", 32'(busy), 1);
        chk("ctl_fd", 32'(ctl_now()), 0);
        chk("pc_fd", 32'(pc), 32'(m_pc));
        if (k == poke_at) start = 1'b1;
        tick();
        start = 1'b0;
      end
      ins = rom[m_pc]; op = ins[7:4]; v = ins[3:0];
      chk("ctl_exec", 32'(ctl_now()), 32'(exp_ctl(op)));
      chk("oprnd_exec", 32'(oprnd), 32'(v));
      chk("pc_exec", 32'(pc), 32'(m_pc));
      chk("busy_exec", 32'(busy), 1);
      case (op)
        4'h1: m_acc = v;
        4'h2: begin s = {1'b0, m_acc} + {1'b0, v}; m_acc = s[3:0]; m_c = s[4]; m_z = (s[3:0] == 0); end
        4'h3: begin m_c = (m_acc >= v); m_acc = m_acc - v; m_z = (m_acc == 0); end
        4'h4: begin m_acc = ~(m_acc & v); m_c = 1'b0; m_z = (m_acc == 0); end
        default: ;
      endcase
      if (op == 4'hF) m_halt = 1'b1;
      else if (op == 4'h6 || (op == 4'h7 && m_c) || (op == 4'h8 && m_z)) m_pc = v;
      else m_pc = m_pc + 4'd1;
      tick();
    end
    if (m_halt) begin
      chk("halted", 32'(halted), 1);
      chk("busy_halt", 32'(busy), 0);
      chk("pc_halt", 32'(pc), 32'(m_pc));
      chk("ctl_halt", 32'(ctl_now()), 0);
    end
    chk("acc", 32'(acc), 32'(m_acc));
  endtask

  typedef struct {
    logic [7:0] ins;
    logic [5:0] ctl;
    logic [3:0] pc_nx;
    logic       hlt;
  } vec_t;

  vec_t tv [12];

  initial begin
    reset = 1'b1; start = 1'b0; acc_clr = 1'b1; m_acc = 4'd0;
    fill_rom(8'hF0);

    tv[0]  = '{8'h00, 6'b000_000, 4'd1,  1'b0};
    tv[1]  = '{8'h15, 6'b101_010, 4'd1,  1'b0};
    tv[2]  = '{8'h23, 6'b101_011, 4'd1,  1'b0};
    tv[3]  = '{8'h34, 6'b101_001, 4'd1,  1'b0};
    tv[4]  = '{8'h47, 6'b101_100, 4'd1,  1'b0};
    tv[5]  = '{8'h50, 6'b010_000, 4'd1,  1'b0};
    tv[6]  = '{8'h6B, 6'b000_000, 4'd11, 1'b0};
    tv[7]  = '{8'h79, 6'b000_000, 4'd1,  1'b0};
    tv[8]  = '{8'h8A, 6'b000_000, 4'd1,  1'b0};
    tv[9]  = '{8'hF0, 6'b000_000, 4'd0,  1'b1};
    tv[10] = '{8'hA3, 6'b000_000, 4'd1,  1'b0};
    tv[11] = '{8'hC0, 6'b000_000, 4'd1,  1'b0};

    for (int i = 0; i < 12; i++) begin
      do_reset();
      fill_rom(8'hF0);
      rom[0] = tv[i].ins;
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      chk($sformatf("tv%0d_ctl", i), 32'(ctl_now()), 32'(tv[i].ctl));
      chk($sformatf("tv%0d_oprnd", i), 32'(oprnd), 32'(tv[i].ins[3:0]));
      tick();
      chk($sformatf("tv%0d_pc", i), 32'(pc), 32'(tv[i].pc_nx));
      chk($sformatf("tv%0d_halted", i), 32'(halted), 32'(tv[i].hlt));
      chk($sformatf("tv%0d_ctl_after", i), 32'(ctl_now()), 0);
    end

    // Reset asserted mid-EXEC of ADDI: enables drop at once, accumulator keeps 5.
    do_reset();
    fill_rom(8'hF0);
    rom[0] = 8'h15; rom[1] = 8'h23;
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    chk("midexec_ec", 32'(ec), 1);
    #3 reset = 1'b1;
    #1;
    chk("midexec_ctl", 32'(ctl_now()), 0);
    chk("midexec_busy", 32'(busy), 0);
    chk("midexec_pc", 32'(pc), 0);
    chk("midexec_oprnd", 32'(oprnd), 0);
    tick();
    chk("midexec_acc", 32'(acc), 5);
    reset = 1'b0;
    tick(); tick();
    chk("midexec_idle", 32'(busy), 0);
    chk("midexec_halted", 32'(halted), 0);

    // Start coincident with reset is dropped.
    reset = 1'b1; start = 1'b1; tick();
    reset = 1'b0; start = 1'b0; tick();
    chk("rst_start_busy", 32'(busy), 0);

    // LDI 5; ADDI 3; OUT; HALT
    do_reset(); fill_rom(8'hF0);
    rom[0] = 8'h15; rom[1] = 8'h23; rom[2] = 8'h50;
    run_prog(10, -1);
    chk("prog1_acc", 32'(acc), 8);
    chk("prog1_pc", 32'(pc), 3);
    chk("prog1_halted", 32'(halted), 1);

    // JC taken on carry, then not taken without it.
    do_reset(); fill_rom(8'hF0);
    rom[0] = 8'h1F; rom[1] = 8'h21; rom[2] = 8'h76;
    run_prog(10, -1);
    chk("jc_taken_pc", 32'(pc), 6);
    do_reset(); fill_rom(8'hF0);
    rom[0] = 8'h1F; rom[1] = 8'h20; rom[2] = 8'h76;
    run_prog(10, -1);
    chk("jc_not_taken_pc", 32'(pc), 3);

    // JZ after SUBI to zero, directly and with an OUT in between.
    do_reset(); fill_rom(8'hF0);
    rom[0] = 8'h14; rom[1] = 8'h34; rom[2] = 8'h89;
    run_prog(10, -1);
    chk("jz_pc", 32'(pc), 9);
    do_reset(); fill_rom(8'hF0);
    rom[0] = 8'h14; rom[1] = 8'h34; rom[2] = 8'h50; rom[3] = 8'h89;
    run_prog(10, -1);
    chk("jz_held_pc", 32'(pc), 9);

    // JMP 15 then NOP at 15 wraps to 0; start pulses while busy are ignored.
    do_reset(); fill_rom(8'hF0);
    rom[0] = 8'h6F; rom[15] = 8'h00;
    run_prog(2, 1);
    chk("wrap_pc", 32'(pc), 0);
    chk("wrap_busy", 32'(busy), 1);

    // Opcode 1010 as NOP, then restart from HALT with flags cleared.
    do_reset(); fill_rom(8'hF0);
    rom[0] = 8'h1F; rom[1] = 8'h21; rom[2] = 8'hF0;
    run_prog(10, -1);
    chk("flagset_halt_pc", 32'(pc), 2);
    rom[0] = 8'hA5; rom[1] = 8'h75; rom[2] = 8'h86; rom[3] = 8'hF0;
    run_prog(10, -1);
    chk("restart_pc", 32'(pc), 3);

    // Random programs against the ISA-level model.
    for (int it = 0; it < 20; it++) begin
      do_reset();
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      run_prog(25, int'($urandom_range(0, 30)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
